// File: rtl/qpsk_prbs_checker_if.sv
// Symbol input and BER/lock status bundle between a symbol source and qpsk_prbs_checker.
interface qpsk_prbs_checker_if #(
  parameter int DW    = 16,
  parameter int CNT_W = 32
);
  logic                 in_valid;
  logic signed [DW-1:0] sI_in;
  logic signed [DW-1:0] sQ_in;
  logic                 clear_cnt;
  logic                 lock_I;
  logic                 lock_Q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic [1:0]           err_pulse;

  modport master (
    output in_valid, sI_in, sQ_in, clear_cnt,
    input  lock_I, lock_Q, bit_cnt, err_cnt, err_pulse
  );

  modport slave (
    input  in_valid, sI_in, sQ_in, clear_cnt,
    output lock_I, lock_Q, bit_cnt, err_cnt, err_pulse
  );
endinterface

// File: rtl/qpsk_prbs_checker.sv
// Hard-sliced QPSK receive checker: per-lane self-synchronising PRBS9 lock plus
// saturating bit/error counters for BER measurement. Lane index 1 = I, 0 = Q.
module qpsk_prbs_checker #(
  parameter int DW       = 16,
  parameter int LOCK_CNT = 32,
  parameter int WIN      = 128,
  parameter int ERR_THR  = 16,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  qpsk_prbs_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);

  localparam logic [0:0]    ST_SEARCH  = 1'b0;
  localparam logic [0:0]    ST_LOCKED  = 1'b1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
  localparam logic [WW:0]   ERR_LIM    = (WW + 1)'(ERR_THR);

  // b[n] = b[n-9] ^ b[n-5] with h[0] the newest bit and h[8] the oldest
  function automatic logic prbs_tap(input logic [8:0] h);
    return h[8] ^ h[4];
  endfunction

  logic [1:0]          state_q, state_d;
  logic [1:0][8:0]     hist_q, hist_d;
  logic [1:0][8:0]     gen_q, gen_d;
  logic [1:0][3:0]     fill_q, fill_d;
  logic [1:0][MW-1:0]  match_q, match_d;
  logic [1:0][WW-1:0]  win_q, win_d;
  logic [1:0][WW-1:0]  werr_q, werr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [1:0]          err_pulse_q, err_pulse_d;

  logic [1:0]          rx_s;
  logic [1:0]          gen_bit_s;
  logic [1:0]          mis_s;
  logic [1:0][WW:0]    werr_tot_s;
  logic [1:0]          bit_inc_s;
  logic [1:0]          err_inc_s;
  logic [CNT_W:0]      bit_sum_s;
  logic [CNT_W:0]      err_sum_s;

  assign rx_s = {bus.sI_in[DW-1], bus.sQ_in[DW-1]};

  // Per-lane SEARCH/LOCKED sequencing; nothing moves without in_valid
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    gen_d      = gen_q;
    fill_d     = fill_q;
    match_d    = match_q;
    win_d      = win_q;
    werr_d     = werr_q;
    gen_bit_s  = 2'b00;
    mis_s      = 2'b00;
    werr_tot_s = '0;
    for (int l = 0; l < 2; l++) begin
      gen_bit_s[l]  = prbs_tap(gen_q[l]);
      mis_s[l]      = bus.in_valid & (state_q[l] == ST_LOCKED) & (gen_bit_s[l] ^ rx_s[l]);
      werr_tot_s[l] = {1'b0, werr_q[l]} + {{WW{1'b0}}, mis_s[l]};
      if (!bus.in_valid) begin
        state_d[l] = state_q[l];
      end else if (state_q[l] == ST_SEARCH) begin
        hist_d[l] = {hist_q[l][7:0], rx_s[l]};
        if (fill_q[l] != 4'd9) begin
          fill_d[l] = fill_q[l] + 4'd1;
        end else if (rx_s[l] == prbs_tap(hist_q[l])) begin
          if (match_q[l] == MATCH_LAST) begin
            // Seed from the newest nine received bits, current one included
            state_d[l] = ST_LOCKED;
            gen_d[l]   = {hist_q[l][7:0], rx_s[l]};
            match_d[l] = '0;
            win_d[l]   = '0;
            werr_d[l]  = '0;
          end else begin
            match_d[l] = match_q[l] + MW'(1);
          end
        end else begin
          match_d[l] = '0;
        end
      end else begin
        gen_d[l] = {gen_q[l][7:0], gen_bit_s[l]};
        if (win_q[l] == WIN_LAST) begin
          if (werr_tot_s[l] >= ERR_LIM) begin
            state_d[l] = ST_SEARCH;
            fill_d[l]  = 4'd0;
            match_d[l] = '0;
          end else begin
            state_d[l] = ST_LOCKED;
          end
          win_d[l]  = '0;
          werr_d[l] = '0;
        end else begin
          win_d[l]  = win_q[l] + WW'(1);
          werr_d[l] = werr_tot_s[l][WW-1:0];
        end
      end
    end
  end

  // Saturating counters; the increment uses lock state before this symbol's update
  always_comb begin
    bit_inc_s   = {1'b0, state_q[1]} + {1'b0, state_q[0]};
    err_inc_s   = {1'b0, mis_s[1]} + {1'b0, mis_s[0]};
    bit_sum_s   = {1'b0, bit_cnt_q} + {{(CNT_W-1){1'b0}}, bit_inc_s};
    err_sum_s   = {1'b0, err_cnt_q} + {{(CNT_W-1){1'b0}}, err_inc_s};
    err_pulse_d = mis_s;
    if (bus.clear_cnt) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (!bus.in_valid) begin
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
    end else begin
      bit_cnt_d = bit_sum_s[CNT_W] ? {CNT_W{1'b1}} : bit_sum_s[CNT_W-1:0];
      err_cnt_d = err_sum_s[CNT_W] ? {CNT_W{1'b1}} : err_sum_s[CNT_W-1:0];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= {ST_SEARCH, ST_SEARCH};
      hist_q      <= '0;
      gen_q       <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      gen_q       <= gen_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.lock_I    = (state_q[1] == ST_LOCKED);
  assign bus.lock_Q    = (state_q[0] == ST_LOCKED);
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_qpsk_prbs_checker.sv
// Directed-sequence bench with randomized symbols, checked every cycle against a
// bit-history reference model; a second instance with CNT_W=4 covers saturation.
module tb_qpsk_prbs_checker;
  localparam int DW       = 16;
  localparam int LOCK_CNT = 32;
  localparam int WIN      = 128;
  localparam int ERR_THR  = 16;
  localparam int DEPTH    = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;

  qpsk_prbs_checker_if #(.DW(DW), .CNT_W(32)) bus ();
  qpsk_prbs_checker_if #(.DW(DW), .CNT_W(4))  bus4 ();

  qpsk_prbs_checker #(.DW(DW), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_THR(ERR_THR), .CNT_W(32))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));
  qpsk_prbs_checker #(.DW(DW), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_THR(ERR_THR), .CNT_W(4))
    dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] src [2];
  bit         rnd_mode;

  // Reference model: lane 0 = I, lane 1 = Q
  bit     m_lock [2];
  int     m_run [2];
  int     m_since [2];
  int     m_werr [2];
  bit     rxa [2][DEPTH];
  int     rxn [2];
  bit     ga [2][DEPTH];
  int     gn [2];
  longint m_bits;
  longint m_errs;
  logic [1:0] m_pulse;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_lock[l] = 1'b0; m_run[l] = 0; m_since[l] = 0; m_werr[l] = 0;
      rxn[l] = 0; gn[l] = 0;
    end
    m_bits = 0; m_errs = 0; m_pulse = 2'b00;
  endtask

  task automatic model_lane(input int l, input bit r, output bit mis);
    bit e;
    mis = 1'b0;
    if (m_lock[l]) begin
      e = ga[l][gn[l]-9] ^ ga[l][gn[l]-5];
      ga[l][gn[l]] = e;
      gn[l]++;
      mis = (e != r);
      m_since[l]++;
      m_werr[l] += int'(mis);
      if (m_since[l] == WIN) begin
        if (m_werr[l] >= ERR_THR) begin
          m_lock[l] = 1'b0; rxn[l] = 0; m_run[l] = 0;
        end
        m_since[l] = 0; m_werr[l] = 0;
      end
    end else begin
      rxa[l][rxn[l]] = r;
      rxn[l]++;
      if (rxn[l] >= 10) begin
        if (r == (rxa[l][rxn[l]-10] ^ rxa[l][rxn[l]-6])) m_run[l]++;
        else m_run[l] = 0;
        if (m_run[l] == LOCK_CNT) begin
          m_lock[l] = 1'b1;
          for (int k = 0; k < 9; k++) ga[l][k] = rxa[l][rxn[l]-9+k];
          gn[l] = 9; m_since[l] = 0; m_werr[l] = 0; m_run[l] = 0;
        end
      end
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input bit r_i, input bit r_q, input bit clr);
    longint ib;
    bit mi, mq;
    mi = 1'b0; mq = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      ib = longint'(m_lock[0]) + longint'(m_lock[1]);
      if (v) begin
        model_lane(0, r_i, mi);
        model_lane(1, r_q, mq);
      end else begin
        ib = 0;
      end
      m_pulse = {mi, mq};
      if (clr) begin
        m_bits = 0; m_errs = 0;
      end else begin
        m_bits += ib;
        m_errs += longint'(mi) + longint'(mq);
      end
    end
  endtask

  task automatic gen_bit(input int l, output bit b);
    if (rnd_mode) begin
      b = 1'($urandom_range(1, 0));
    end else begin
      b = src[l][8] ^ src[l][4];
      src[l] = {src[l][7:0], b};
    end
  endtask

  function automatic logic signed [DW-1:0] mk_sym(input bit b);
    int a;
    if (b) begin
      a = int'($urandom_range(1 << (DW-1), 1));
      return DW'(-a);
    end else begin
      a = int'($urandom_range((1 << (DW-1)) - 1, 0));
      return DW'(a);
    end
  endfunction

  task automatic check_all();
    chk("lock_I",     64'(bus.lock_I),    64'(m_lock[0]));
    chk("lock_Q",     64'(bus.lock_Q),    64'(m_lock[1]));
    chk("bit_cnt",    64'(bus.bit_cnt),   64'(sat(m_bits, 32)));
    chk("err_cnt",    64'(bus.err_cnt),   64'(sat(m_errs, 32)));
    chk("err_pulse",  64'(bus.err_pulse), 64'(m_pulse));
    chk("bit_cnt_w4", 64'(bus4.bit_cnt),  64'(sat(m_bits, 4)));
    chk("err_cnt_w4", 64'(bus4.err_cnt),  64'(sat(m_errs, 4)));
  endtask

  task automatic step(input bit v, input bit fi, input bit fq, input bit clr, input bit rst);
    bit b_i, b_q;
    logic signed [DW-1:0] s_i, s_q;
    if (v) begin
      gen_bit(0, b_i); gen_bit(1, b_q);
      s_i = mk_sym(b_i ^ fi);
      s_q = mk_sym(b_q ^ fq);
    end else begin
      s_i = DW'($urandom);
      s_q = DW'($urandom);
    end
    reset = rst;
    bus.in_valid  = v;   bus4.in_valid  = v;
    bus.sI_in     = s_i; bus4.sI_in     = s_i;
    bus.sQ_in     = s_q; bus4.sQ_in     = s_q;
    bus.clear_cnt = clr; bus4.clear_cnt = clr;
    @(posedge clk);
    #1;
    model_step(rst, v, s_i < 0, s_q < 0, clr);
    check_all();
  endtask

  task automatic run_clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart_source();
    src[0] = 9'h17F;
    src[1] = 9'h11D;
  endtask

  initial begin
    bit pos [WIN];
    int cnt, p, rem;
    rnd_mode = 1'b0;
    restart_source();
    model_reset();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_lock_I", 64'(bus.lock_I), 64'd0);
    chk("rst_err_pulse", 64'(bus.err_pulse), 64'd0);

    // Continuous loopback: lock on valid #41, then 100 more valids
    restart_source();
    run_clean(40);
    chk("lock_I_at_40", 64'(bus.lock_I), 64'd0);
    run_clean(1);
    chk("lock_I_at_41", 64'(bus.lock_I), 64'd1);
    chk("lock_Q_at_41", 64'(bus.lock_Q), 64'd1);
    run_clean(100);
    chk("loop_bit_cnt", 64'(bus.bit_cnt), 64'd200);
    chk("loop_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("loop_bit_sat4", 64'(bus4.bit_cnt), 64'd15);

    // Single inverted I symbol
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_pulse", 64'(bus.err_pulse), 64'd2);
    chk("single_err", 64'(bus.err_cnt), 64'd1);
    chk("single_lock_I", 64'(bus.lock_I), 64'd1);
    run_clean(1);
    chk("single_pulse_clr", 64'(bus.err_pulse), 64'd0);

    // Finish current window, then ERR_THR I errors in one window
    rem = WIN - m_since[0];
    run_clean(rem);
    for (int i = 0; i < WIN; i++) pos[i] = 1'b0;
    cnt = 0;
    while (cnt < ERR_THR) begin
      p = int'($urandom_range(WIN - 1, 0));
      if (!pos[p]) begin pos[p] = 1'b1; cnt++; end
    end
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, pos[i], 1'b0, 1'b0, 1'b0);
      if (i == WIN - 2) chk("lol_hold_I", 64'(bus.lock_I), 64'd1);
    end
    chk("lol_lock_I", 64'(bus.lock_I), 64'd0);
    chk("lol_lock_Q", 64'(bus.lock_Q), 64'd1);
    chk("lol_err_cnt", 64'(bus.err_cnt), 64'(1 + ERR_THR));
    chk("lol_err_sat4", 64'(bus4.err_cnt), 64'd15);
    run_clean(40);
    chk("relock_I_40", 64'(bus.lock_I), 64'd0);
    run_clean(1);
    chk("relock_I_41", 64'(bus.lock_I), 64'd1);

    // clear_cnt on an error cycle, and on an idle cycle
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("clr_pulse", 64'(bus.err_pulse), 64'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_idle_err", 64'(bus.err_cnt), 64'd0);

    // Reset while locked
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstlk_lock_I", 64'(bus.lock_I), 64'd0);
    chk("rstlk_bit_cnt", 64'(bus.bit_cnt), 64'd0);
    run_clean(40);
    chk("rstlk_relock_40", 64'(bus.lock_Q), 64'd0);
    run_clean(1);
    chk("rstlk_relock_41", 64'(bus.lock_Q), 64'd1);

    // Gapped valid pattern 1,0,0
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    restart_source();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("gap_lock_40", 64'(bus.lock_I), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_lock_I_41", 64'(bus.lock_I), 64'd1);
    chk("gap_lock_Q_41", 64'(bus.lock_Q), 64'd1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("gap_bit_cnt", 64'(bus.bit_cnt), 64'd200);
    chk("gap_err_cnt", 64'(bus.err_cnt), 64'd0);

    // Non-PRBS random data never locks
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rnd_mode = 1'b1;
    run_clean(10000);
    chk("rnd_lock_I", 64'(bus.lock_I), 64'd0);
    chk("rnd_lock_Q", 64'(bus.lock_Q), 64'd0);
    chk("rnd_bit_cnt", 64'(bus.bit_cnt), 64'd0);
    chk("rnd_err_cnt", 64'(bus.err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
